// File: rtl/store_merge_unit_if.sv
// Bundle of request, memory and status signals for the store merge unit.
interface store_merge_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              misalign_err;

    // Environment side: issues store requests and answers memory accesses.
    modport master (
        output start, size, addr, wdata, mem_rdata, mem_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done, misalign_err
    );

    // Store merge unit side.
    modport slave (
        input  start, size, addr, wdata, mem_rdata, mem_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done, misalign_err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Store merge unit: turns byte/halfword stores into read-modify-write of a full
// memory word and passes aligned full-word stores straight through as a single write.
module store_merge_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input logic               clk,
    input logic               reset_n,
    store_merge_unit_if.slave bus
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q, merge_d;

    logic [OFF_W-1:0]  off_in;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  off_hi_q;
    logic              reject;
    logic              accept;
    logic              capture;

    assign off_in   = bus.addr[OFF_W-1:0];
    assign off_q    = addr_q[OFF_W-1:0];
    // Upper lane of an accepted halfword; its offset is always even.
    assign off_hi_q = {off_q[OFF_W-1:1], 1'b1};

    // Classify the incoming request: reserved size or misaligned address is rejected.
    always_comb begin
        reject = 1'b0;
        case (bus.size)
            SzByte:  reject = 1'b0;
            SzHalf:  reject = bus.addr[0];
            SzWord:  reject = (off_in != '0);
            default: reject = 1'b1;
        endcase
    end

    // Next-state logic and the load strobes for the request and merge registers.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (reject) begin
                        state_d = StErr;
                    end else if (bus.size == SzWord) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (bus.mem_ready) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus.mem_ready) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Overlay the store data onto the word being read back from memory.
    always_comb begin
        merge_d = bus.mem_rdata;
        for (int k = 0; k < int'(LANES); k++) begin
            if ((size_q == SzByte || size_q == SzHalf) && OFF_W'(k) == off_q) begin
                merge_d[8*k +: 8] = wdata_q[7:0];
            end
            if (size_q == SzHalf && OFF_W'(k) == off_hi_q) begin
                merge_d[8*k +: 8] = wdata_q[15:8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture at acceptance and merged-word capture at read completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                size_q  <= bus.size;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (capture) begin
                merge_q <= merge_d;
            end
        end
    end

    // Outputs decode purely from registered state, so reset clears them at once.
    always_comb begin
        bus.mem_req      = (state_q == StRead) || (state_q == StWrite);
        bus.mem_we       = (state_q == StWrite);
        bus.mem_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        // Full-word stores skip the read, so the latched data goes out untouched.
        bus.mem_wdata    = (size_q == SzWord) ? wdata_q : merge_q;
        bus.busy         = (state_q != StIdle);
        bus.done         = (state_q == StDone);
        bus.misalign_err = (state_q == StErr);
    end
endmodule
